// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   DIGITS_W          : width of the packed BCD digit bus
//   DB_CYCLES_DEFAULT : stable cycles a button needs (20 ms at 50 MHz)
//   DB_WIDTH_DEFAULT  : debounce counter width able to hold DB_CYCLES_DEFAULT-1
//   ST_*              : FSM state encodings, also visible on o_state
package stopwatch_pkg;

    localparam int DIGITS_W          = 32;
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int DB_WIDTH_DEFAULT  = 20;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

endpackage

// File: rtl/sw_debounce.sv
// Button conditioning: 2-flop synchronizer, debouncer and rising-edge detector.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous button, active-high
//   press : one-cycle pulse, DB_CYCLES+3 edges after a stable raw rise
module sw_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int DB_WIDTH  = DB_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    // Terminal count: the DB_CYCLES-th consecutive disagreeing sample flips the level.
    localparam logic [DB_WIDTH-1:0] CNT_TC  = DB_WIDTH'(DB_CYCLES - 1);
    localparam logic [DB_WIDTH-1:0] CNT_ONE = DB_WIDTH'(1);

    logic [1:0]          sync;
    logic                level;
    logic                level_q;
    logic [DB_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync[1] == level) begin
            cnt <= '0;
        end else if (cnt == CNT_TC) begin
            level <= sync[1];
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounces the two buttons, sequences the counter
// enable/clear and freezes the display for lap times.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | stopped at zero; lap_reset press re-clears the counter
//   RUN    | counting, display live
//   PAUSE  | stopped, display live; lap_reset press clears to IDLE
//   LAP    | counting, display frozen on captured lap value
//
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_start_stop   : raw start/stop button
//   i_lap_reset    : raw lap/reset button
//   i_digits       : live BCD digits from the counter
//   o_en           : counter enable (RUN or LAP)
//   o_sclr         : registered one-cycle counter clear (high in reset)
//   o_lap_hold     : display frozen (LAP)
//   o_disp         : digits to display
//   o_state        : current FSM state
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int DB_WIDTH  = DB_WIDTH_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start_stop,
    input  logic                i_lap_reset,
    input  logic [DIGITS_W-1:0] i_digits,
    output logic                o_en,
    output logic                o_sclr,
    output logic                o_lap_hold,
    output logic [DIGITS_W-1:0] o_disp,
    output logic [1:0]          o_state
);

    logic                ss_press;
    logic                lr_press;
    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                clr_nxt;
    logic                capture;
    logic [DIGITS_W-1:0] lap_reg;

    sw_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_WIDTH  (DB_WIDTH)
    ) u_db_start_stop (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .btn   (i_start_stop),
        .press (ss_press)
    );

    sw_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_WIDTH  (DB_WIDTH)
    ) u_db_lap_reset (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .btn   (i_lap_reset),
        .press (lr_press)
    );

    // start_stop is tested first in every state, so a simultaneous
    // lap_reset press is dropped.
    always_comb begin
        state_nxt = state;
        clr_nxt   = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_press) begin
                    state_nxt = ST_RUN;
                end else if (lr_press) begin
                    clr_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (ss_press) begin
                    state_nxt = ST_PAUSE;
                end else if (lr_press) begin
                    state_nxt = ST_LAP;
                    capture   = 1'b1;
                end
            end
            ST_LAP: begin
                if (ss_press) begin
                    state_nxt = ST_PAUSE;
                end else if (lr_press) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (ss_press) begin
                    state_nxt = ST_RUN;
                end else if (lr_press) begin
                    state_nxt = ST_IDLE;
                    clr_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // o_sclr resets high so the counter is held clear until the first edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            o_sclr <= 1'b1;
        end else begin
            state  <= state_nxt;
            o_sclr <= clr_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lap_reg <= '0;
        end else if (capture) begin
            lap_reg <= i_digits;
        end
    end

    assign o_en       = (state == ST_RUN) || (state == ST_LAP);
    assign o_lap_hold = (state == ST_LAP);
    assign o_disp     = o_lap_hold ? lap_reg : i_digits;
    assign o_state    = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start_stop;
    logic        i_lap_reset;
    logic [31:0] i_digits;
    logic        o_en;
    logic        o_sclr;
    logic        o_lap_hold;
    logic [31:0] o_disp;
    logic [1:0]  o_state;

    int n_vec = 0;
    int n_err = 0;

    stopwatch_ctrl #(
        .DB_CYCLES (4),
        .DB_WIDTH  (3)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start_stop (i_start_stop),
        .i_lap_reset  (i_lap_reset),
        .i_digits     (i_digits),
        .o_en         (o_en),
        .o_sclr       (o_sclr),
        .o_lap_hold   (o_lap_hold),
        .o_disp       (o_disp),
        .o_state      (o_state)
    );

    always #10 i_clk = ~i_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold the buttons for n cycles, release, then let the release settle.
    task automatic press(input logic ss, input logic lr, input int n);
        i_start_stop = ss;
        i_lap_reset  = lr;
        tick(n);
        i_start_stop = 1'b0;
        i_lap_reset  = 1'b0;
        tick(12);
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_start_stop = 1'b0;
        i_lap_reset  = 1'b0;
        i_digits     = 32'hABCD_0000;
        tick(3);

        // reset
        chk("rst_state", {30'd0, o_state}, 32'd0);
        chk("rst_en", {31'd0, o_en}, 32'd0);
        chk("rst_sclr", {31'd0, o_sclr}, 32'd1);
        chk("rst_hold", {31'd0, o_lap_hold}, 32'd0);
        chk("rst_disp", o_disp, 32'hABCD_0000);
        i_rst_n = 1'b1;
        #2;
        chk("sclr_before_edge", {31'd0, o_sclr}, 32'd1);
        tick(1);
        chk("sclr_after_edge", {31'd0, o_sclr}, 32'd0);

        // start: o_en rises exactly 8 edges after the input rise
        i_digits     = 32'h0000_0000;
        i_start_stop = 1'b1;
        tick(7);
        chk("start_en_edge7", {31'd0, o_en}, 32'd0);
        tick(1);
        chk("start_en_edge8", {31'd0, o_en}, 32'd1);
        chk("start_state", {30'd0, o_state}, 32'd1);
        tick(2);
        i_start_stop = 1'b0;
        tick(12);
        chk("release_no_toggle", {30'd0, o_state}, 32'd1);

        // pause
        press(1'b1, 1'b0, 10);
        chk("pause_state", {30'd0, o_state}, 32'd2);
        chk("pause_en", {31'd0, o_en}, 32'd0);

        // resume and take a lap
        i_digits = 32'h0000_1234;
        press(1'b1, 1'b0, 10);
        chk("resume_state", {30'd0, o_state}, 32'd1);
        press(1'b0, 1'b1, 10);
        chk("lap_state", {30'd0, o_state}, 32'd3);
        chk("lap_hold", {31'd0, o_lap_hold}, 32'd1);
        chk("lap_en", {31'd0, o_en}, 32'd1);
        i_digits = 32'h0000_5678;
        #1;
        chk("lap_disp_frozen", o_disp, 32'h0000_1234);
        press(1'b0, 1'b1, 10);
        chk("unlap_state", {30'd0, o_state}, 32'd1);
        chk("unlap_disp_live", o_disp, 32'h0000_5678);

        // lap then start_stop: pause with live value shown
        press(1'b0, 1'b1, 10);
        chk("lap2_state", {30'd0, o_state}, 32'd3);
        i_digits = 32'h0000_6000;
        press(1'b1, 1'b0, 10);
        chk("lap_to_pause", {30'd0, o_state}, 32'd2);
        chk("lap_to_pause_disp", o_disp, 32'h0000_6000);

        // clear from pause: o_sclr high for exactly one cycle
        i_lap_reset = 1'b1;
        tick(7);
        chk("clr_state_edge7", {30'd0, o_state}, 32'd2);
        chk("clr_sclr_edge7", {31'd0, o_sclr}, 32'd0);
        tick(1);
        chk("clr_state_edge8", {30'd0, o_state}, 32'd0);
        chk("clr_sclr_edge8", {31'd0, o_sclr}, 32'd1);
        tick(1);
        chk("clr_sclr_edge9", {31'd0, o_sclr}, 32'd0);
        tick(1);
        i_lap_reset = 1'b0;
        tick(12);

        // glitches of 3 cycles are ignored, 4 stable cycles register
        press(1'b1, 1'b0, 3);
        chk("glitch3_state", {30'd0, o_state}, 32'd0);
        press(1'b1, 1'b1, 3);
        chk("glitch3_both", {30'd0, o_state}, 32'd0);
        press(1'b1, 1'b0, 4);
        chk("stable4_state", {30'd0, o_state}, 32'd1);

        // simultaneous presses from RUN: start_stop wins
        i_digits = 32'h0000_9999;
        press(1'b1, 1'b1, 10);
        chk("both_state", {30'd0, o_state}, 32'd2);
        chk("both_hold", {31'd0, o_lap_hold}, 32'd0);
        chk("both_disp", o_disp, 32'h0000_9999);

        // reset mid-debounce with button held through release
        i_start_stop = 1'b1;
        tick(3);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_state", {30'd0, o_state}, 32'd0);
        chk("midrst_sclr", {31'd0, o_sclr}, 32'd1);
        tick(2);
        i_rst_n = 1'b1;
        tick(7);
        chk("held_en_edge7", {31'd0, o_en}, 32'd0);
        tick(1);
        chk("held_en_edge8", {31'd0, o_en}, 32'd1);
        i_start_stop = 1'b0;
        tick(12);
        chk("held_final_state", {30'd0, o_state}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, is the number of consecutive stable cycles a button needs (20 ms at 50 MHz); the legal range is 2 or more.
REQ-002 Parameter DB_WIDTH, default 20, is the width of the debounce counter and SHALL hold DB_CYCLES-1.
REQ-003 Port i_clk: input, 1 bit, system clock; all logic is in this single clock domain.
REQ-004 Port i_rst_n: input, 1 bit, reset that is asynchronous and active-low.
REQ-005 Port i_start_stop: input, 1 bit, raw start/stop button, active-high, asynchronous.
REQ-006 Port i_lap_reset: input, 1 bit, raw lap/reset button, active-high, asynchronous.
REQ-007 Port i_digits: input, 32 bits, live stopwatch digits from the counter, BCD, order {hr_0,hr_1,min_0,min_1,sec_0,sec_1,sec_2,sec_3}.
REQ-008 Port o_en: output, 1 bit, count enable to the stopwatch counter.
REQ-009 Port o_sclr: output, 1 bit, synchronous clear to the stopwatch counter.
REQ-010 Port o_lap_hold: output, 1 bit, high while the display is frozen.
REQ-011 Port o_disp: output, 32 bits, digits to display.
REQ-012 Port o_state: output, 2 bits, current FSM state.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then the debouncer, then a rising-edge detector that produces a one-cycle press pulse.
REQ-014 The debounced level SHALL change only after the synchronized input has differed from it for DB_CYCLES consecutive cycles; any agreeing sample restarts the count.
REQ-015 A raw rising edge held stable SHALL produce a press pulse exactly DB_CYCLES+3 clock edges later; the FSM and outputs update on the following edge.
REQ-016 FSM states and encodings: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-017 IDLE transitions: a start_stop press goes to RUN; a lap_reset press stays in IDLE and pulses o_sclr.
REQ-018 RUN transitions: a start_stop press goes to PAUSE; a lap_reset press goes to LAP and captures i_digits into the lap register on that edge.
REQ-019 LAP transitions: a start_stop press goes to PAUSE; a lap_reset press goes to RUN.
REQ-020 PAUSE transitions: a start_stop press goes to RUN; a lap_reset press goes to IDLE and pulses o_sclr.
REQ-021 If both press pulses occur in the same cycle, start_stop SHALL win and the lap_reset press is discarded.
REQ-022 o_en SHALL be 1 exactly when the state is RUN or LAP.
REQ-023 o_lap_hold SHALL be 1 exactly when the state is LAP.
REQ-024 o_sclr SHALL be registered and high for exactly one cycle per clearing event.
REQ-025 o_disp SHALL equal the lap register when o_lap_hold=1 and i_digits otherwise, combinationally.
REQ-026 o_state SHALL equal the state register.
REQ-027 The counter keeps running in LAP; leaving LAP via start_stop SHALL show the live value, which is paused.

Reset
REQ-028 While i_rst_n=0: state IDLE; o_en=0; o_sclr=1; lap register 0; synchronizers, debounced levels, edge history and counters all 0.
REQ-029 o_sclr SHALL fall on the first clock edge after i_rst_n deasserts.
REQ-030 A reset mid-debounce SHALL discard the partial count.
REQ-031 A button held high through reset release SHALL produce one press pulse DB_CYCLES+3 edges after release.

Structure
REQ-032 Shared package stopwatch_pkg SHALL hold the state encodings, DIGITS_W=32 and the DB_CYCLES default.
REQ-033 Sub-module sw_debounce (synchronizer, debouncer and edge detector, parameterized by DB_CYCLES and DB_WIDTH) SHALL be instantiated once per button.
REQ-034 The RTL SHALL not exceed 400 lines.

Verification
REQ-035 The bench SHALL use DB_CYCLES=4 and a 20 ns clock.
REQ-036 Reset check: drive i_rst_n=0 and release -> o_state=0, o_en=0, o_sclr=1 until the first edge after release, then 0.
REQ-037 Start/stop check: start_stop high for 10 cycles -> o_en rises 8 edges after the input rise. A second press -> o_state=2 and o_en=0.
REQ-038 Lap check: in RUN with i_digits=32'h00001234, press lap_reset -> o_state=3 and o_disp stays 32'h00001234 while i_digits changes. Press lap_reset again -> o_disp tracks i_digits.
REQ-039 Clear check: in PAUSE, press lap_reset -> o_state=0 and o_sclr high for exactly 1 cycle.
REQ-040 Bounce and simultaneity check: a glitch of 3 cycles or fewer -> no state change. Both buttons pressed in the same cycle from RUN -> PAUSE, no lap capture.
